pcpu_lsu: RTL and testbench
===========================

Name: pcpu_lsu

Overview:
- Parametrised load/store unit for the pipelined CPU memory stage.
- Replaces the fixed word-only access path with byte, half, word and (64-bit builds) doubleword loads and stores.
- Handles byte lanes, load sign/zero extension and alignment checking, and supports wait states via the MIO_ready handshake.
- Issues a pipeline stall while an access is outstanding and aborts accesses that exceed a bounded wait.

Parameters:
- DATA_W, 32: data bus width; legal values are 32 or 64.
- ADDR_W, 32: address width.
- WAIT_MAX, 16: maximum cycles to wait for MIO_ready before aborting; must be ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  memory-stage access request.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_W=64).
- req_sext  in  1  load result is sign-extended when 1, zero-extended when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- mem_req  out  1  access active toward memory/MIO.
- mem_w  out  1  write strobe.
- mem_be  out  DATA_W/8  byte enables.
- Addr_out  out  ADDR_W  bus-aligned address (low log2(DATA_W/8) bits forced to 0).
- Data_out  out  DATA_W  lane-replicated store data.
- MIO_ready  in  1  memory completes the access this cycle.
- Data_in  in  DATA_W  read data, valid when MIO_ready=1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load result.
- stall  out  1  hold upstream pipeline stages.
- err_misalign  out  1  one-cycle pulse: misaligned or illegal request.
- err_timeout  out  1  one-cycle pulse: access aborted after WAIT_MAX cycles.

Behaviour:
- States: IDLE, BUSY, DONE.
- req_ready = (state==IDLE) | (state==DONE).
- stall = (state==BUSY).
- Reset (reset=0 at a clock edge):
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0, including mem_req, mem_w, mem_be, Addr_out, Data_out, resp_valid, resp_rdata and both err pulses.
  - Reset mid-access abandons the access; mem_req is 0 after that edge and no response or error is produced.
- Accept: req_valid & req_ready at an edge.
- Misalignment or illegality is any of:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - doubleword with addr[2:0]≠0;
  - size 11 when DATA_W=32.
  - Such a request is consumed: err_misalign=1 for the next cycle, no memory access, and state goes (or returns) to IDLE.
- Legal accept: the next state is BUSY. Request fields are registered. Drive:
  - mem_req=1;
  - mem_w=req_we;
  - Addr_out = aligned address;
  - mem_be = size mask shifted left by offset (byte 1, half 2'b11, word 4'hF, doubleword 8'hFF);
  - Data_out = req_wdata low 8/16/32/64 bits replicated across the bus.
- Loads also assert mem_be for the accessed bytes. The little-endian offset is addr[log2(DATA_W/8)-1:0].
- BUSY:
  - The wait counter increments each cycle.
  - If MIO_ready=1: go to DONE. For loads, resp_rdata = (Data_in >> 8*offset) truncated to the access size, then extended per req_sext to DATA_W. For stores, resp_rdata=0. resp_valid=1 in DONE.
  - Else if the counter reaches WAIT_MAX-1: go to IDLE and pulse err_timeout for one cycle, with no resp_valid.
  - mem_req and the registered outputs hold stable for the whole BUSY state.
- DONE:
  - Lasts exactly one cycle; mem_req=0 unless a new request is accepted in this same cycle, in which case the next state is BUSY (back-to-back).
  - resp_rdata holds its value until the next completion.
- Zero-wait latency: accept at edge N; BUSY at N+1 (MIO_ready seen); DONE/resp_valid at N+2. Sustained throughput is one access per 2 cycles.
- MIO_ready is ignored outside BUSY.
- The counter is WAIT_MAX-bounded and saturating; it clears on entering BUSY.

Test Plan:
- Word store: addr 0x104, wdata 0xDEADBEEF, MIO_ready=1 → Addr_out=0x104, mem_be=4'hF, mem_w=1, stall 1 cycle, resp_valid 2 cycles after accept.
- Byte loads: Data_in=0x80FF7F01 at addr 0x203.
  - sext → resp_rdata=0xFFFFFF80.
  - zext → 0x00000080.
  - mem_be=4'b1000.
- Half store/load: addr 0x12, wdata 0x0000ABCD → Data_out=0xABCDABCD, mem_be=4'b1100. Half sext load of Data_in=0x8001_0000 → 0xFFFF8001.
- Wait states and timeout:
  - MIO_ready held low 3 cycles → stall high 4 cycles, Addr_out stable, single resp_valid.
  - Ready never asserted with WAIT_MAX=16 → err_timeout pulse after 16 BUSY cycles, state IDLE.
- Errors: half at 0x11, word at 0x102, and size 11 with DATA_W=32 → err_misalign pulse each, mem_req never asserted. DATA_W=64 doubleword at 0x18 → mem_be=8'hFF.
- Reset and back-to-back: reset=0 during BUSY → next cycle mem_req=0, no resp_valid. A new request accepted during DONE → BUSY on the following cycle with no idle gap.

Source files
------------

// File: rtl/pcpu_lsu.sv
// pcpu_lsu: memory-stage load/store unit with byte lanes, load extension,
// alignment checking, MIO_ready wait states and a bounded-wait abort.
module pcpu_lsu #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_req,
    output logic                mem_w,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   Addr_out,
    output logic [DATA_W-1:0]   Data_out,
    input  logic                MIO_ready,
    input  logic [DATA_W-1:0]   Data_in,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                stall,
    output logic                err_misalign,
    output logic                err_timeout
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CW    = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_we, r_sext;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [OFF_W-1:0]  w_off;
    logic              w_acc, w_bad, w_go, w_to, w_sb;
    logic [BE_W-1:0]   w_mask;
    logic [DATA_W-1:0] w_rep, w_sh, w_lmask, w_ld;

    assign req_ready = (r_state == IDLE) || (r_state == DONE);
    assign stall     = (r_state == BUSY);
    assign w_off     = req_addr[OFF_W-1:0];
    assign w_acc     = req_valid && req_ready;
    assign w_bad     = ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (|req_addr[1:0]))
                    || ((req_size == 2'b11) && ((DATA_W == 32) || (|req_addr[2:0])));
    assign w_go      = w_acc && !w_bad;
    assign w_to      = (r_state == BUSY) && !MIO_ready && (r_cnt == CW'(WAIT_MAX - 1));

    always_comb begin
        w_mask  = (req_size == 2'b00) ? BE_W'(1) : (req_size == 2'b01) ? BE_W'(3)
                : (req_size == 2'b10) ? BE_W'(15) : '1;
        w_rep   = (req_size == 2'b00) ? {BE_W{req_wdata[7:0]}}
                : (req_size == 2'b01) ? {(BE_W/2){req_wdata[15:0]}}
                : (req_size == 2'b10) ? {(DATA_W/32){req_wdata[31:0]}} : req_wdata;
        // Load path: move the addressed lane to bit 0, keep the access width, extend.
        w_sh    = Data_in >> {r_off, 3'b000};
        w_lmask = (r_size == 2'b00) ? DATA_W'(64'hFF) : (r_size == 2'b01) ? DATA_W'(64'hFFFF)
                : (r_size == 2'b10) ? DATA_W'(64'hFFFF_FFFF) : '1;
        w_sb    = (r_size == 2'b00) ? w_sh[7] : (r_size == 2'b01) ? w_sh[15]
                : (r_size == 2'b10) ? w_sh[31] : w_sh[DATA_W-1];
        w_ld    = (w_sh & w_lmask) | (~w_lmask & {DATA_W{w_sb && r_sext}});
        w_next  = (r_state == BUSY) ? (MIO_ready ? DONE : w_to ? IDLE : BUSY)
                : (w_go ? BUSY : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_sext       <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= '0;
            mem_req      <= 1'b0;
            mem_w        <= 1'b0;
            mem_be       <= '0;
            Addr_out     <= '0;
            Data_out     <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            r_state      <= w_next;
            mem_req      <= (w_next == BUSY);
            resp_valid   <= (r_state == BUSY) && MIO_ready;
            err_timeout  <= w_to;
            err_misalign <= w_acc && w_bad;
            r_cnt        <= w_go ? '0
                          : ((r_state == BUSY) && (r_cnt != CW'(WAIT_MAX))) ? r_cnt + 1'b1 : r_cnt;
            if (w_go) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_sext   <= req_sext;
                r_off    <= w_off;
                mem_w    <= req_we;
                mem_be   <= w_mask << w_off;
                Addr_out <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                Data_out <= w_rep;
            end
            if ((r_state == BUSY) && MIO_ready)
                resp_rdata <= r_we ? '0 : w_ld;
        end
    end
endmodule

// File: tb/tb_pcpu_lsu.sv
// tb_pcpu_lsu: scoreboard bench for pcpu_lsu, 32-bit and 64-bit builds side by side.
module tb_pcpu_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, rv64 = 1'b0;
    logic        req_we = 1'b0, req_sext = 1'b0, MIO_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [63:0] wdata = '0, din64 = '0;
    logic [31:0] din32 = '0;

    logic        req_ready, mem_req, mem_w, resp_valid, stall, err_misalign, err_timeout;
    logic [3:0]  mem_be;
    logic [31:0] Addr_out, Data_out, resp_rdata;
    logic        req_ready_64, mem_req_64, mem_w_64, resp_valid_64, stall_64, err_misalign_64, err_timeout_64;
    logic [7:0]  mem_be_64;
    logic [31:0] Addr_out_64;
    logic [63:0] Data_out_64, resp_rdata_64;

    int vectors = 0;
    int errs = 0;
    logic [63:0] q32[$];
    logic [63:0] q64[$];
    logic [63:0] exp_v;

    always #5 clk = ~clk;

    pcpu_lsu #(.DATA_W(32), .ADDR_W(32), .WAIT_MAX(16)) dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(wdata[31:0]), .mem_req(mem_req), .mem_w(mem_w), .mem_be(mem_be),
        .Addr_out(Addr_out), .Data_out(Data_out), .MIO_ready(MIO_ready), .Data_in(din32),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
        .err_misalign(err_misalign), .err_timeout(err_timeout));

    pcpu_lsu #(.DATA_W(64), .ADDR_W(32), .WAIT_MAX(16)) dut64 (
        .clk(clk), .reset(reset), .req_valid(rv64), .req_ready(req_ready_64),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(wdata), .mem_req(mem_req_64), .mem_w(mem_w_64), .mem_be(mem_be_64),
        .Addr_out(Addr_out_64), .Data_out(Data_out_64), .MIO_ready(MIO_ready), .Data_in(din64),
        .resp_valid(resp_valid_64), .resp_rdata(resp_rdata_64), .stall(stall_64),
        .err_misalign(err_misalign_64), .err_timeout(err_timeout_64));

    // Response monitor: every completion pops the oldest expected value.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            vectors++;
            if (q32.size() == 0) begin
                errs++;
                $display("FAIL resp32_unexpected got=%h", resp_rdata);
            end else begin
                exp_v = q32.pop_front();
                if (resp_rdata !== exp_v[31:0]) begin
                    errs++;
                    $display("FAIL resp32_data got=%h exp=%h", resp_rdata, exp_v[31:0]);
                end
            end
        end
        if (resp_valid_64 === 1'b1) begin
            vectors++;
            if (q64.size() == 0) begin
                errs++;
                $display("FAIL resp64_unexpected got=%h", resp_rdata_64);
            end else begin
                exp_v = q64.pop_front();
                if (resp_rdata_64 !== exp_v) begin
                    errs++;
                    $display("FAIL resp64_data got=%h exp=%h", resp_rdata_64, exp_v);
                end
            end
        end
    end

    // Drives one request so it is accepted at the next rising edge; returns 1ns after it.
    task automatic issue(input bit d64, input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [63:0] wd, input bit push,
                         input logic [63:0] exp);
        @(negedge clk);
        #1;
        req_we = we; req_size = sz; req_sext = sx; req_addr = a; wdata = wd;
        if (d64) rv64 = 1'b1; else req_valid = 1'b1;
        if (push && d64) q64.push_back(exp);
        if (push && !d64) q32.push_back(exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rv64 = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({mem_req, mem_w, mem_be, resp_valid, stall, err_misalign, err_timeout} !== 10'd0) begin
            errs++;
            $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_w, mem_be, resp_valid, stall, err_misalign, err_timeout});
        end
        vectors++;
        if ({Addr_out, Data_out, resp_rdata} !== 96'd0) begin
            errs++;
            $display("FAIL reset_data got=%h exp=0", {Addr_out, Data_out, resp_rdata});
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_store();
        MIO_ready = 1'b1;
        issue(0, 1'b1, 2'b10, 1'b0, 32'h104, 64'hDEADBEEF, 1, 64'h0);
        vectors++;
        if ({Addr_out, mem_be, mem_w, stall, mem_req} !== {32'h104, 4'hF, 3'b111}) begin
            errs++;
            $display("FAIL wstore_issue got=%h/%h/%b%b%b exp=104/f/111", Addr_out, mem_be, mem_w, stall, mem_req);
        end
        vectors++;
        if (Data_out !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL wstore_data got=%h exp=deadbeef", Data_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({stall, resp_valid, mem_req} !== 3'b010) begin
            errs++;
            $display("FAIL wstore_done got=%b exp=010", {stall, resp_valid, mem_req});
        end
        settle();
    endtask

    task automatic test_byte_load();
        MIO_ready = 1'b1;
        din32 = 32'h80FF7F01;
        issue(0, 1'b0, 2'b00, 1'b1, 32'h203, 64'h0, 1, 64'hFFFFFF80);
        vectors++;
        if ({mem_be, Addr_out, mem_w} !== {4'b1000, 32'h200, 1'b0}) begin
            errs++;
            $display("FAIL bload_issue got=%b/%h/%b exp=1000/200/0", mem_be, Addr_out, mem_w);
        end
        settle();
        issue(0, 1'b0, 2'b00, 1'b0, 32'h203, 64'h0, 1, 64'h80);
        vectors++;
        if (mem_be !== 4'b1000) begin
            errs++;
            $display("FAIL bload_be got=%b exp=1000", mem_be);
        end
        settle();
    endtask

    task automatic test_half();
        MIO_ready = 1'b1;
        issue(0, 1'b1, 2'b01, 1'b0, 32'h12, 64'h0000ABCD, 1, 64'h0);
        vectors++;
        if ({Data_out, mem_be, Addr_out} !== {32'hABCDABCD, 4'b1100, 32'h10}) begin
            errs++;
            $display("FAIL hstore_issue got=%h/%b/%h exp=abcdabcd/1100/10", Data_out, mem_be, Addr_out);
        end
        settle();
        din32 = 32'h80010000;
        issue(0, 1'b0, 2'b01, 1'b1, 32'h12, 64'h0, 1, 64'hFFFF8001);
        settle();
    endtask

    task automatic test_wait_states();
        int sc, rv;
        sc = 0;
        rv = 0;
        MIO_ready = 1'b0;
        din32 = 32'h12345678;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 64'h0, 1, 64'h12345678);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall === 1'b1) begin
                sc++;
                vectors++;
                if (Addr_out !== 32'h40) begin
                    errs++;
                    $display("FAIL wait_addr_stable got=%h exp=40", Addr_out);
                end
                if (sc == 4) MIO_ready = 1'b1;
            end
            if (resp_valid === 1'b1) rv++;
        end
        vectors++;
        if (sc != 4) begin
            errs++;
            $display("FAIL wait_stall_cycles got=%0d exp=4", sc);
        end
        vectors++;
        if (rv != 1) begin
            errs++;
            $display("FAIL wait_resp_count got=%0d exp=1", rv);
        end
    endtask

    task automatic test_timeout();
        int sc, ec, rv;
        sc = 0;
        ec = 0;
        rv = 0;
        MIO_ready = 1'b0;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h80, 64'h0, 0, 64'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stall === 1'b1) sc++;
            if (err_timeout === 1'b1) ec++;
            if (resp_valid === 1'b1) rv++;
        end
        vectors++;
        if ({sc, ec, rv} !== {32'd16, 32'd1, 32'd0}) begin
            errs++;
            $display("FAIL timeout_counts got=%0d/%0d/%0d exp=16/1/0", sc, ec, rv);
        end
        vectors++;
        if ({stall, req_ready, mem_req} !== 3'b010) begin
            errs++;
            $display("FAIL timeout_idle got=%b exp=010", {stall, req_ready, mem_req});
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  sz_t[3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] ad_t[3] = '{32'h11, 32'h102, 32'h100};
        MIO_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(0, 1'b0, sz_t[i], 1'b0, ad_t[i], 64'h0, 0, 64'h0);
            vectors++;
            if ({err_misalign, mem_req, stall} !== 3'b100) begin
                errs++;
                $display("FAIL misalign_%0d got=%b exp=100", i, {err_misalign, mem_req, stall});
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({err_misalign, mem_req} !== 2'b00) begin
                errs++;
                $display("FAIL misalign_pulse_%0d got=%b exp=00", i, {err_misalign, mem_req});
            end
        end
        issue(1, 1'b1, 2'b11, 1'b0, 32'h18, 64'h0123456789ABCDEF, 1, 64'h0);
        vectors++;
        if ({mem_be_64, Addr_out_64, err_misalign_64} !== {8'hFF, 32'h18, 1'b0}) begin
            errs++;
            $display("FAIL dw_store got=%h/%h/%b exp=ff/18/0", mem_be_64, Addr_out_64, err_misalign_64);
        end
        vectors++;
        if (Data_out_64 !== 64'h0123456789ABCDEF) begin
            errs++;
            $display("FAIL dw_data got=%h exp=0123456789abcdef", Data_out_64);
        end
        settle();
        din64 = 64'h0000_9A00_0000_0000;
        issue(1, 1'b0, 2'b00, 1'b1, 32'h1D, 64'h0, 1, 64'hFFFFFFFFFFFFFF9A);
        vectors++;
        if ({mem_be_64, Addr_out_64} !== {8'b0010_0000, 32'h18}) begin
            errs++;
            $display("FAIL b64_issue got=%b/%h exp=00100000/18", mem_be_64, Addr_out_64);
        end
        settle();
        issue(1, 1'b0, 2'b11, 1'b0, 32'h1C, 64'h0, 0, 64'h0);
        vectors++;
        if ({err_misalign_64, mem_req_64} !== 2'b10) begin
            errs++;
            $display("FAIL dw_misalign got=%b exp=10", {err_misalign_64, mem_req_64});
        end
        settle();
    endtask

    task automatic test_reset_busy();
        int bad;
        bad = 0;
        MIO_ready = 1'b0;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h44, 64'h0, 0, 64'h0);
        vectors++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL rbusy_stall got=%b exp=1", stall);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({mem_req, stall} !== 2'b00) begin
            errs++;
            $display("FAIL rbusy_abort got=%b exp=00", {mem_req, stall});
        end
        reset = 1'b1;
        MIO_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ((resp_valid | err_timeout | err_misalign) !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errs++;
            $display("FAIL rbusy_no_resp got=%0d exp=0", bad);
        end
    endtask

    task automatic test_back_to_back();
        MIO_ready = 1'b1;
        din32 = 32'hCAFEF00D;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h60, 64'h0, 1, 64'hCAFEF00D);
        @(posedge clk);
        #1;
        vectors++;
        if ({resp_valid, req_ready} !== 2'b11) begin
            errs++;
            $display("FAIL b2b_done got=%b exp=11", {resp_valid, req_ready});
        end
        din32 = 32'h0BADBEEF;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h64, 64'h0, 1, 64'h0BADBEEF);
        vectors++;
        if ({stall, mem_req, resp_valid, Addr_out} !== {3'b110, 32'h64}) begin
            errs++;
            $display("FAIL b2b_busy got=%b/%h exp=110/64", {stall, mem_req, resp_valid}, Addr_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (resp_valid !== 1'b1) begin
            errs++;
            $display("FAIL b2b_resp got=%b exp=1", resp_valid);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half();
        test_wait_states();
        test_timeout();
        test_misalign();
        test_reset_busy();
        test_back_to_back();
        vectors++;
        if (q32.size() + q64.size() != 0) begin
            errs++;
            $display("FAIL pending_responses got=%0d exp=0", q32.size() + q64.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
